interval_timer: RTL and testbench

Measures the time between two rising edges of an event input, in units of CLOCK_FREQ/CLOCK_DIVIDER clock cycles (microseconds by default). It is the measuring counterpart to the load-and-count-down timer: software arms it, and it counts up from the first event edge until the second edge or a programmed limit. Results are held for software readback. It sits on the system clock next to the other support timers and is written and read through the card's register interface.

---
 rtl/interval_timer.sv | 175 +++++++++++++++++
 tb/tb_interval_timer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/interval_timer.sv
// -----------------------------------------------------------------------------
// interval_timer
//
// Measures the interval between two rising edges of event_i in units of
// CPC = CLOCK_FREQ/CLOCK_DIVIDER clock cycles. Software arms the block. The
// first rising edge starts the count. The next rising edge stops it, or the
// count stops when it reaches the limit or all-ones saturation. The result is
// held until the block is armed again or aborted.
//
// Ports
//   clk       system clock, all logic on the rising edge
//   reset_n   asynchronous active-low reset
//   arm       one-cycle pulse: clear the result and wait for a start edge
//   abort     one-cycle pulse: return to IDLE and clear the result
//   event_i   event level, synchronous to clk (only rising edges are used)
//   limit     timeout in units; 0 = only all-ones saturation applies
//   elapsed   measured interval in units
//   busy      measurement armed or in progress
//   valid     measurement complete, result held
//   overflow  measurement ended on the limit or on saturation
//
// State table
//   state   | meaning
//   IDLE    | no measurement, elapsed = 0
//   ARMED   | waiting for the start edge
//   RUNNING | counting units until the stop edge or the limit
//   DONE    | result held for readback
// -----------------------------------------------------------------------------
module interval_timer #(
  parameter int CLOCK_FREQ    = 54_000_000,
  parameter int CLOCK_DIVIDER = 1_000_000,
  parameter int WIDTH         = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             arm,
  input  logic             abort,
  input  logic             event_i,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] elapsed,
  output logic             busy,
  output logic             valid,
  output logic             overflow
);

  localparam int CPC   = CLOCK_FREQ / CLOCK_DIVIDER;
  localparam int PRE_W = (CPC > 1) ? $clog2(CPC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CPC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   prescaler_q, prescaler_d;
  logic [WIDTH-1:0]   elapsed_q, elapsed_d;
  logic               overflow_q, overflow_d;
  logic               event_q;

  logic               rise;
  logic               tick;
  logic [WIDTH-1:0]   lim_eff;
  logic               at_cap;
  logic               at_limit;

  assign rise = event_i & ~event_q;
  assign tick = (state_q == RUNNING) && (prescaler_q == PRE_LAST);

  // A zero limit means "count until all-ones".
  assign lim_eff = (limit == '0) ? '1 : limit;

  // at_cap: elapsed is already at or beyond the limit (limit was lowered
  // while running), so the next tick must not increment it.
  // at_limit: the next tick reaches or has passed the limit and ends the run.
  // lim_eff is never 0, so lim_eff - 1 cannot underflow.
  assign at_cap   = (elapsed_q >= lim_eff);
  assign at_limit = (elapsed_q >= (lim_eff - WIDTH'(1)));

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      prescaler_q <= '0;
      elapsed_q   <= '0;
      overflow_q  <= 1'b0;
      event_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      prescaler_q <= prescaler_d;
      elapsed_q   <= elapsed_d;
      overflow_q  <= overflow_d;
      event_q     <= event_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // Priority: abort, then arm, then rise, then tick.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    prescaler_d = prescaler_q;
    elapsed_d   = elapsed_q;
    overflow_d  = overflow_q;

    if (abort) begin
      state_d     = IDLE;
      prescaler_d = '0;
      elapsed_d   = '0;
      overflow_d  = 1'b0;
    end else if (arm) begin
      // A rise in the same cycle as arm is discarded on purpose.
      state_d     = ARMED;
      prescaler_d = '0;
      elapsed_d   = '0;
      overflow_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
        end

        ARMED: begin
          if (rise) begin
            state_d     = RUNNING;
            prescaler_d = '0;
            elapsed_d   = '0;
            overflow_d  = 1'b0;
          end
        end

        RUNNING: begin
          if (rise) begin
            // Stop edge wins over a coincident tick: elapsed stays frozen.
            state_d    = DONE;
            overflow_d = 1'b0;
          end else if (tick) begin
            prescaler_d = '0;
            if (!at_cap) begin
              elapsed_d = elapsed_q + WIDTH'(1);
            end
            if (at_limit) begin
              state_d    = DONE;
              overflow_d = 1'b1;
            end
          end else begin
            prescaler_d = prescaler_q + PRE_W'(1);
          end
        end

        DONE: begin
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registers only
  // ---------------------------------------------------------------------------
  always_comb begin
    elapsed  = elapsed_q;
    busy     = (state_q == ARMED) || (state_q == RUNNING);
    valid    = (state_q == DONE);
    overflow = overflow_q;
  end

endmodule

// File: tb/tb_interval_timer.sv
// -----------------------------------------------------------------------------
// tb_interval_timer
//
// Directed bench for interval_timer with CLOCK_FREQ=4, CLOCK_DIVIDER=1 (CPC=4)
// and WIDTH=4. Inputs are driven and outputs sampled on the falling edge, so
// each "cycles(1)" consumes exactly one rising edge of clk.
// -----------------------------------------------------------------------------
module tb_interval_timer;

  localparam int W = 4;

  logic         clk;
  logic         reset_n;
  logic         arm;
  logic         abort;
  logic         event_i;
  logic [W-1:0] limit;
  logic [W-1:0] elapsed;
  logic         busy;
  logic         valid;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  interval_timer #(
    .CLOCK_FREQ   (4),
    .CLOCK_DIVIDER(1),
    .WIDTH        (W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .arm     (arm),
    .abort   (abort),
    .event_i (event_i),
    .limit   (limit),
    .elapsed (elapsed),
    .busy    (busy),
    .valid   (valid),
    .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int e_elapsed, input int e_busy,
                         input int e_valid, input int e_ovf);
    chk($sformatf("%s.elapsed", tag),  32'(elapsed),  e_elapsed);
    chk($sformatf("%s.busy", tag),     32'(busy),     e_busy);
    chk($sformatf("%s.valid", tag),    32'(valid),    e_valid);
    chk($sformatf("%s.overflow", tag), 32'(overflow), e_ovf);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    cycles(1);
    arm = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    arm     = 1'b0;
    abort   = 1'b0;
    event_i = 1'b0;
    limit   = '0;

    // Reset state
    cycles(2);
    chk_out("reset", 0, 0, 0, 0);
    reset_n = 1'b1;
    cycles(2);
    chk_out("idle", 0, 0, 0, 0);

    // Basic measurement: start at S, stop at S+21 -> 21/4 = 5 units
    pulse_arm();
    chk_out("armed", 0, 1, 0, 0);
    cycles(2);
    chk_out("armed_wait", 0, 1, 0, 0);
    event_i = 1'b1;
    cycles(1);
    chk_out("start", 0, 1, 0, 0);
    event_i = 1'b0;
    cycles(20);
    chk_out("run_s20", 5, 1, 0, 0);
    event_i = 1'b1;
    cycles(1);
    chk_out("stop_s21", 5, 0, 1, 0);
    event_i = 1'b0;
    cycles(5);
    event_i = 1'b1;
    cycles(45);
    chk_out("held50", 5, 0, 1, 0);

    // Stop exactly on a tick edge (S+4): stop wins, elapsed 0
    pulse_arm();
    event_i = 1'b0;
    cycles(1);
    event_i = 1'b1;
    cycles(1);
    event_i = 1'b0;
    cycles(3);
    event_i = 1'b1;
    cycles(1);
    chk_out("stop_tick", 0, 0, 1, 0);

    // Stop one cycle later (S+5): elapsed 1
    arm     = 1'b1;
    event_i = 1'b0;
    cycles(1);
    arm     = 1'b0;
    event_i = 1'b1;
    cycles(1);
    event_i = 1'b0;
    cycles(4);
    chk_out("run_s4", 1, 1, 0, 0);
    event_i = 1'b1;
    cycles(1);
    chk_out("stop_s5", 1, 0, 1, 0);

    // Limit 3: done 12 cycles after start, overflow set
    limit   = 4'd3;
    arm     = 1'b1;
    event_i = 1'b0;
    cycles(1);
    arm     = 1'b0;
    event_i = 1'b1;
    cycles(1);
    cycles(11);
    chk_out("lim_s11", 2, 1, 0, 0);
    cycles(1);
    chk_out("lim_s12", 3, 0, 1, 1);
    event_i = 1'b0;
    cycles(1);
    event_i = 1'b1;
    cycles(8);
    chk_out("lim_rise_ignored", 3, 0, 1, 1);

    // Saturation at all-ones (15) with limit 0, 60 cycles after start
    limit   = '0;
    arm     = 1'b1;
    event_i = 1'b0;
    cycles(1);
    arm     = 1'b0;
    event_i = 1'b1;
    cycles(1);
    cycles(59);
    chk_out("sat_s59", 14, 1, 0, 0);
    cycles(1);
    chk_out("sat_s60", 15, 0, 1, 1);
    cycles(8);
    chk_out("sat_hold", 15, 0, 1, 1);

    // Limit lowered below elapsed while running: stop at next tick, no increment
    arm     = 1'b1;
    event_i = 1'b0;
    cycles(1);
    arm     = 1'b0;
    event_i = 1'b1;
    cycles(1);
    cycles(13);
    chk_out("lower_s13", 3, 1, 0, 0);
    limit = 4'd2;
    cycles(2);
    chk_out("lower_s15", 3, 1, 0, 0);
    cycles(1);
    chk_out("lower_s16", 3, 0, 1, 1);
    limit = '0;

    // arm and rise together: ARMED, and held-high event does not start
    event_i = 1'b0;
    cycles(1);
    arm     = 1'b1;
    event_i = 1'b1;
    cycles(1);
    arm     = 1'b0;
    chk_out("arm_rise", 0, 1, 0, 0);
    cycles(8);
    chk_out("arm_held_high", 0, 1, 0, 0);
    event_i = 1'b0;
    cycles(1);
    event_i = 1'b1;
    cycles(1);
    cycles(4);
    chk_out("restart_s4", 1, 1, 0, 0);

    // abort and arm together while running: IDLE, cleared
    abort = 1'b1;
    arm   = 1'b1;
    cycles(1);
    abort = 1'b0;
    arm   = 1'b0;
    chk_out("abort_arm", 0, 0, 0, 0);
    event_i = 1'b0;
    cycles(1);
    event_i = 1'b1;
    cycles(6);
    chk_out("idle_rise_ignored", 0, 0, 0, 0);

    // Reset mid-run at elapsed 7: outputs clear without a clock edge
    pulse_arm();
    event_i = 1'b0;
    cycles(1);
    event_i = 1'b1;
    cycles(1);
    cycles(28);
    chk_out("pre_reset_s28", 7, 1, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk_out("async_reset", 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    event_i = 1'b0;
    cycles(1);
    event_i = 1'b1;
    cycles(3);
    chk_out("post_reset_idle", 0, 0, 0, 0);
    pulse_arm();
    chk_out("post_reset_arm", 0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
